// File: rtl/key_event_queue.sv
// Serialises debounced key presses into a small event FIFO with typematic auto-repeat.
// One event per cycle; pending presses take priority over the repeat request.
module key_event_queue #(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [23:0] REPEAT_DELAY  = 24'd2_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd500_000,
  parameter logic [31:0] REPEAT_MASK   = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   held_down,
  input  logic [31:0]                   just_pressed,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [4:0]                    ev_code,
  output logic                          ev_repeat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [31:0]      pend;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       mem_code [FIFO_DEPTH];
  logic             mem_rpt  [FIFO_DEPTH];
  logic             rpt_active, rpt_req;
  logic [4:0]       rpt_key;
  logic [23:0]      rpt_cnt;

  logic        push_slot, push_press, push_rpt, push, pop;
  logic [4:0]  press_idx, push_code;
  logic [31:0] grant;
  logic        rpt_fire, pend_merge, rpt_merge;

  always_comb begin
    press_idx  = lowest_idx(pend);
    // A same-cycle pop never frees the slot: only the registered level counts.
    push_slot  = fifo_level < LVL_W'(FIFO_DEPTH);
    push_press = push_slot && (pend != '0);
    push_rpt   = push_slot && (pend == '0) && rpt_req;
    push       = push_press || push_rpt;
    pop        = ev_valid && ev_ready;
    grant      = push_press ? (32'd1 << press_idx) : '0;
    push_code  = push_press ? press_idx : rpt_key;
    rpt_fire   = rpt_active && held_down[rpt_key] && (rpt_cnt == '0);
    pend_merge = |(just_pressed & pend & ~grant);
    rpt_merge  = !push_press && rpt_fire && rpt_req && !push_rpt;
  end

  assign ev_valid  = (fifo_level != '0);
  assign ev_code   = ev_valid ? mem_code[rd_ptr] : 5'd0;
  assign ev_repeat = ev_valid ? mem_rpt[rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr] <= push_code;
      mem_rpt[wr_ptr]  <= push_rpt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      rpt_active <= 1'b0;
      rpt_req    <= 1'b0;
      rpt_key    <= '0;
      rpt_cnt    <= '0;
    end else begin
      pend       <= (pend & ~grant) | just_pressed;
      overflow   <= pend_merge || rpt_merge;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);

      // A press push retargets the tracker and overrides any countdown update.
      if (push_press) begin
        rpt_req <= 1'b0;
        if (REPEAT_MASK[press_idx]) begin
          rpt_active <= 1'b1;
          rpt_key    <= press_idx;
          rpt_cnt    <= REPEAT_DELAY - 24'd1;
        end else begin
          rpt_active <= 1'b0;
        end
      end else begin
        if (push_rpt) rpt_req <= 1'b0;
        if (rpt_active) begin
          if (!held_down[rpt_key]) begin
            rpt_active <= 1'b0;
            rpt_req    <= 1'b0;
          end else if (rpt_cnt == '0) begin
            rpt_req <= 1'b1;
            rpt_cnt <= REPEAT_PERIOD - 24'd1;
          end else begin
            rpt_cnt <= rpt_cnt - 24'd1;
          end
        end
      end
    end
  end
endmodule
